// File: rtl/rx_pkg.sv
// Shared definitions for the NanEye RX word deserializer: framer state
// encoding, serial framing bit values and default frame geometry.
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        SHIFT = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    localparam int DEF_WORD_W  = 10;
    localparam int DEF_COLS    = 250;
    localparam int DEF_ROWS    = 250;
    localparam int DEF_TIMEOUT = 1024;
    localparam int DEF_ERR_W   = 8;

    // Width of an index counting 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rx_word_framer.sv
// Start/stop word framer: hunts for a start bit, shifts WORD_W data bits
// (MSB first) and validates the stop bit. word_valid/frame_err are strobes
// in the cycle the stop bit is consumed; word is stable while in STOP.
module rx_word_framer
    import rx_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              bit_in,
    input  logic              bit_en,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic              frame_err,
    output logic              in_frame
);

    localparam int CNT_W = idx_w(WORD_W);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              last_bit;

    assign last_bit = (bit_cnt == CNT_W'(WORD_W - 1));

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a (re)start outranks an abort from the top level.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        if (start) begin
            state_nxt = HUNT;
        end else if (abort) begin
            state_nxt = IDLE;
        end else if (bit_en) begin
            case (state)
                HUNT:    if (bit_in == START_BIT) state_nxt = SHIFT;
                SHIFT:   if (last_bit) state_nxt = STOP;
                STOP:    state_nxt = (bit_in == STOP_BIT) ? HUNT : IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // Output decode: stop-bit verdict strobes and frame activity.
    always_comb begin
        word_valid = 1'b0;
        frame_err  = 1'b0;
        in_frame   = (state != IDLE);
        word       = shreg;
        if (state == STOP && bit_en) begin
            word_valid = (bit_in == STOP_BIT);
            frame_err  = (bit_in != STOP_BIT);
        end
    end

    // Shift register and bit counter; contents only matter inside SHIFT/STOP.
    always_ff @(posedge clk) begin
        // NOTE: pure datapath, no reset; the FSM never uses it before reloading.
        if (state == HUNT && bit_en && bit_in == START_BIT) begin
            bit_cnt <= '0;
        end else if (state == SHIFT && bit_en) begin
            shreg   <= {shreg[WORD_W-2:0], bit_in};
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rx_word_deserializer.sv
// NanEye RX word deserializer: frames decoded serial bits into pixel words,
// tracks column/row inside a ROWS x COLS frame, and handles timeouts,
// aborted frames, decoder resync requests and a saturating error count.
module rx_word_deserializer
    import rx_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int ERR_W   = DEF_ERR_W
) (
    input  logic                     SCLOCK,
    input  logic                     RESET,
    input  logic                     ENABLE,
    input  logic                     FRAME_START,
    input  logic                     SER_INPUT,
    input  logic                     SER_INPUT_EN,
    output logic [WORD_W-1:0]        PIX_DATA,
    output logic                     PIX_VALID,
    output logic [idx_w(COLS)-1:0]   PIX_COL,
    output logic [idx_w(ROWS)-1:0]   PIX_ROW,
    output logic                     LINE_END,
    output logic                     FRAME_END,
    output logic                     DEC_RSYNC,
    output logic [ERR_W-1:0]         ERR_CNT,
    output logic                     BUSY
);

    localparam int COL_W = idx_w(COLS);
    localparam int ROW_W = idx_w(ROWS);
    localparam int GAP_W = idx_w(TIMEOUT);

    logic              word_valid;
    logic              frame_err;
    logic              in_frame;
    logic [WORD_W-1:0] word;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [GAP_W-1:0]  gap_cnt;

    logic start_acc, abort_evt, pix_evt, ferr_evt, timeout_evt;
    logic last_col, last_row, frame_end_evt, err_inc, framer_abort;

    // A restart in the same cycle overrides any other event of that cycle.
    assign start_acc     = ENABLE && FRAME_START;
    assign abort_evt     = start_acc && in_frame;
    assign pix_evt       = ENABLE && word_valid && !start_acc;
    assign ferr_evt      = ENABLE && frame_err && !start_acc;
    assign timeout_evt   = ENABLE && in_frame && !SER_INPUT_EN && !start_acc
                           && (gap_cnt == GAP_W'(TIMEOUT - 1));
    assign last_col      = (col == COL_W'(COLS - 1));
    assign last_row      = (row == ROW_W'(ROWS - 1));
    assign frame_end_evt = pix_evt && last_col && last_row;
    assign err_inc       = abort_evt || ferr_evt || timeout_evt;
    assign framer_abort  = !ENABLE || timeout_evt || frame_end_evt;
    assign BUSY          = in_frame;

    rx_word_framer #(
        .WORD_W (WORD_W)
    ) u_framer (
        .clk        (SCLOCK),
        .rst_n      (RESET),
        .start      (start_acc),
        .abort      (framer_abort),
        .bit_in     (SER_INPUT),
        .bit_en     (SER_INPUT_EN),
        .word_valid (word_valid),
        .word       (word),
        .frame_err  (frame_err),
        .in_frame   (in_frame)
    );

    // Stream gap counter: counts idle cycles while a frame is active.
    always_ff @(posedge SCLOCK) begin
        if (!RESET || !in_frame || SER_INPUT_EN || start_acc) gap_cnt <= '0;
        else                                                   gap_cnt <= gap_cnt + GAP_W'(1);
    end

    // Column/row position, cleared on every accepted frame start.
    always_ff @(posedge SCLOCK) begin
        if (!RESET || start_acc) begin
            col <= '0;
            row <= '0;
        end else if (pix_evt) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Registered pixel, status strobes and saturating error counter.
    always_ff @(posedge SCLOCK) begin
        if (!RESET) begin
            PIX_DATA  <= '0;
            PIX_VALID <= 1'b0;
            PIX_COL   <= '0;
            PIX_ROW   <= '0;
            LINE_END  <= 1'b0;
            FRAME_END <= 1'b0;
            DEC_RSYNC <= 1'b0;
            ERR_CNT   <= '0;
        end else begin
            PIX_VALID <= pix_evt;
            LINE_END  <= pix_evt && last_col;
            FRAME_END <= frame_end_evt;
            DEC_RSYNC <= ferr_evt || timeout_evt;
            if (pix_evt) begin
                PIX_DATA <= word;
                PIX_COL  <= col;
                PIX_ROW  <= row;
            end
            if (err_inc && ERR_CNT != '1) ERR_CNT <= ERR_CNT + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_rx_word_deserializer.sv
// Self-checking bench for rx_word_deserializer: a scoreboard queue holds the
// pixels expected from the driven words, a monitor pops and compares them.
module tb_rx_word_deserializer;

    localparam int W    = 10;
    localparam int COLS = 3;
    localparam int ROWS = 2;
    localparam int TO   = 16;
    localparam int EW   = 8;

    logic SCLOCK = 1'b0;
    logic RESET = 1'b0;
    logic ENABLE = 1'b0;
    logic FRAME_START = 1'b0;
    logic SER_INPUT = 1'b0;
    logic SER_INPUT_EN = 1'b0;

    logic [W-1:0]  PIX_DATA;
    logic          PIX_VALID;
    logic [1:0]    PIX_COL;
    logic [0:0]    PIX_ROW;
    logic          LINE_END;
    logic          FRAME_END;
    logic          DEC_RSYNC;
    logic [EW-1:0] ERR_CNT;
    logic          BUSY;

    rx_word_deserializer #(
        .WORD_W (W), .COLS (COLS), .ROWS (ROWS), .TIMEOUT (TO), .ERR_W (EW)
    ) dut (
        .SCLOCK       (SCLOCK),
        .RESET        (RESET),
        .ENABLE       (ENABLE),
        .FRAME_START  (FRAME_START),
        .SER_INPUT    (SER_INPUT),
        .SER_INPUT_EN (SER_INPUT_EN),
        .PIX_DATA     (PIX_DATA),
        .PIX_VALID    (PIX_VALID),
        .PIX_COL      (PIX_COL),
        .PIX_ROW      (PIX_ROW),
        .LINE_END     (LINE_END),
        .FRAME_END    (FRAME_END),
        .DEC_RSYNC    (DEC_RSYNC),
        .ERR_CNT      (ERR_CNT),
        .BUSY         (BUSY)
    );

    always #5 SCLOCK = ~SCLOCK;

    typedef struct {
        logic [W-1:0] data;
        int           col;
        int           row;
        bit           le;
        bit           fe;
    } pix_t;

    pix_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rsync_cnt = 0;
    int   pix_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input int c, input int r, input bit le, input bit fe);
        pix_t p;
        p.data = d; p.col = c; p.row = r; p.le = le; p.fe = fe;
        exp_q.push_back(p);
    endtask

    // Monitor: compares every pixel strobe against the scoreboard.
    always @(negedge SCLOCK) begin
        pix_t e;
        if (DEC_RSYNC) rsync_cnt++;
        if (PIX_VALID) begin
            pix_cnt++;
            if (exp_q.size() == 0) begin
                check("pix_unexpected", {22'b0, PIX_DATA}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("pix_data", {22'b0, PIX_DATA}, {22'b0, e.data});
                check("pix_col", {30'b0, PIX_COL}, e.col);
                check("pix_row", {31'b0, PIX_ROW}, e.row);
                check("line_end", {31'b0, LINE_END}, {31'b0, e.le});
                check("frame_end", {31'b0, FRAME_END}, {31'b0, e.fe});
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge SCLOCK);
            SER_INPUT_EN = 1'b0;
            FRAME_START  = 1'b0;
        end
    endtask

    task automatic drive_bit(input logic b, input int idle, input logic fs = 1'b0);
        idle_cycles(idle);
        @(negedge SCLOCK);
        SER_INPUT    = b;
        SER_INPUT_EN = 1'b1;
        FRAME_START  = fs;
    endtask

    task automatic pulse_start();
        @(negedge SCLOCK);
        FRAME_START  = 1'b1;
        SER_INPUT_EN = 1'b0;
        @(negedge SCLOCK);
        FRAME_START  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge SCLOCK);
        RESET = 1'b0; SER_INPUT_EN = 1'b0; FRAME_START = 1'b0;
        @(negedge SCLOCK);
        RESET = 1'b1;
    endtask

    // Sends 1,data(MSB first),stop; checks the strobes one cycle after the stop bit.
    task automatic send_word(input logic [W-1:0] d, input logic stop, input int gap,
                             input bit exp_pix, input bit exp_rs, input logic fs = 1'b0);
        drive_bit(1'b1, gap);
        for (int i = W - 1; i >= 0; i--) drive_bit(d[i], gap);
        drive_bit(stop, gap, fs);
        @(negedge SCLOCK);
        SER_INPUT_EN = 1'b0;
        FRAME_START  = 1'b0;
        check("pix_latency", {31'b0, PIX_VALID}, {31'b0, exp_pix});
        check("rsync_pulse", {31'b0, DEC_RSYNC}, {31'b0, exp_rs});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d;
        int rs0;

        ENABLE = 1'b1;
        repeat (2) @(negedge SCLOCK);
        RESET = 1'b1;
        check("rst_valid", {31'b0, PIX_VALID}, 0);
        check("rst_busy", {31'b0, BUSY}, 0);
        check("rst_err", {24'b0, ERR_CNT}, 0);
        check("rst_rsync", {31'b0, DEC_RSYNC}, 0);
        check("rst_data", {22'b0, PIX_DATA}, 0);

        // 1. Full frame, one bit every 4th cycle.
        pix_cnt = 0;
        pulse_start();
        check("t1_busy_start", {31'b0, BUSY}, 1);
        for (int i = 0; i < 6; i++) begin
            push(W'(i + 1), i % 3, i / 3, (i % 3) == 2, i == 5);
            send_word(W'(i + 1), 1'b0, 3, 1'b1, 1'b0);
        end
        idle_cycles(3);
        check("t1_busy_end", {31'b0, BUSY}, 0);
        check("t1_err", {24'b0, ERR_CNT}, 0);
        check("t1_pix_cnt", pix_cnt, 6);
        check("t1_q_empty", exp_q.size(), 0);

        // 2. Bad stop bit on the second word; later words ignored.
        do_reset();
        rs0 = rsync_cnt;
        pulse_start();
        push(W'(1), 0, 0, 0, 0);
        send_word(W'(1), 1'b0, 1, 1'b1, 1'b0);
        send_word(W'(10'h2AA), 1'b1, 1, 1'b0, 1'b1);
        check("t2_err", {24'b0, ERR_CNT}, 1);
        check("t2_busy", {31'b0, BUSY}, 0);
        send_word(W'(3), 1'b0, 1, 1'b0, 1'b0);
        idle_cycles(2);
        check("t2_err_hold", {24'b0, ERR_CNT}, 1);
        check("t2_rsync_cnt", rsync_cnt - rs0, 1);

        // 3. Stall of TIMEOUT cycles mid-word, then one cycle shorter.
        do_reset();
        d = W'(10'h155);
        pulse_start();
        drive_bit(1'b1, 0);
        for (int i = W - 1; i >= 5; i--) drive_bit(d[i], 0);
        idle_cycles(TO - 1);
        @(negedge SCLOCK);
        SER_INPUT_EN = 1'b0;
        check("t3_no_rsync_early", {31'b0, DEC_RSYNC}, 0);
        check("t3_busy_early", {31'b0, BUSY}, 1);
        @(negedge SCLOCK);
        check("t3_rsync", {31'b0, DEC_RSYNC}, 1);
        check("t3_err", {24'b0, ERR_CNT}, 1);
        check("t3_busy", {31'b0, BUSY}, 0);
        pulse_start();
        check("t3_err_restart", {24'b0, ERR_CNT}, 1);
        push(d, 0, 0, 0, 0);
        drive_bit(1'b1, 0);
        for (int i = W - 1; i >= 5; i--) drive_bit(d[i], 0);
        drive_bit(d[4], TO - 1);
        for (int i = 3; i >= 0; i--) drive_bit(d[i], 0);
        drive_bit(1'b0, 0);
        @(negedge SCLOCK);
        SER_INPUT_EN = 1'b0;
        check("t3_pix_after_stall", {31'b0, PIX_VALID}, 1);
        check("t3_err_short", {24'b0, ERR_CNT}, 1);

        // 4. FRAME_START after 4 pixels, then coincident with a bad stop.
        do_reset();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            push(W'(16 + i), i % 3, i / 3, (i % 3) == 2, 0);
            send_word(W'(16 + i), 1'b0, 1, 1'b1, 1'b0);
        end
        rs0 = rsync_cnt;
        pulse_start();
        check("t4_err_abort", {24'b0, ERR_CNT}, 1);
        check("t4_busy_abort", {31'b0, BUSY}, 1);
        push(W'(10'h0AB), 0, 0, 0, 0);
        send_word(W'(10'h0AB), 1'b0, 1, 1'b1, 1'b0);
        check("t4_err_hold", {24'b0, ERR_CNT}, 1);
        check("t4_no_rsync", rsync_cnt - rs0, 0);
        do_reset();
        pulse_start();
        push(W'(10'h011), 0, 0, 0, 0);
        send_word(W'(10'h011), 1'b0, 1, 1'b1, 1'b0);
        send_word(W'(10'h2AA), 1'b1, 1, 1'b0, 1'b0, 1'b1);
        check("t4_err_coinc", {24'b0, ERR_CNT}, 1);
        check("t4_busy_coinc", {31'b0, BUSY}, 1);
        push(W'(10'h022), 0, 0, 0, 0);
        send_word(W'(10'h022), 1'b0, 1, 1'b1, 1'b0);
        check("t4_err_coinc_hold", {24'b0, ERR_CNT}, 1);

        // 5. Reset in the middle of SHIFT, then a full frame; then ENABLE drop.
        do_reset();
        pulse_start();
        push(W'(10'h3C5), 0, 0, 0, 0);
        send_word(W'(10'h3C5), 1'b0, 0, 1'b1, 1'b0);
        pulse_start();
        drive_bit(1'b1, 0);
        for (int i = 0; i < 4; i++) drive_bit(i[0], 0);
        @(negedge SCLOCK);
        RESET = 1'b0; SER_INPUT_EN = 1'b0;
        @(negedge SCLOCK);
        RESET = 1'b1;
        check("t5_data0", {22'b0, PIX_DATA}, 0);
        check("t5_valid0", {31'b0, PIX_VALID}, 0);
        check("t5_col0", {30'b0, PIX_COL}, 0);
        check("t5_row0", {31'b0, PIX_ROW}, 0);
        check("t5_le0", {31'b0, LINE_END}, 0);
        check("t5_fe0", {31'b0, FRAME_END}, 0);
        check("t5_rsync0", {31'b0, DEC_RSYNC}, 0);
        check("t5_err0", {24'b0, ERR_CNT}, 0);
        check("t5_busy0", {31'b0, BUSY}, 0);
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            d = W'(10'h200 + i * 10'h031);
            push(d, i % 3, i / 3, (i % 3) == 2, i == 5);
            send_word(d, 1'b0, 0, 1'b1, 1'b0);
        end
        idle_cycles(2);
        check("t5_busy_end", {31'b0, BUSY}, 0);
        check("t5_err_end", {24'b0, ERR_CNT}, 0);
        pulse_start();
        drive_bit(1'b1, 0);
        drive_bit(1'b1, 0);
        @(negedge SCLOCK);
        ENABLE = 1'b0; SER_INPUT_EN = 1'b0;
        @(negedge SCLOCK);
        ENABLE = 1'b1;
        check("t5_disable_busy", {31'b0, BUSY}, 0);
        check("t5_disable_err", {24'b0, ERR_CNT}, 0);

        // 6. Saturation of the error counter.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            pulse_start();
            send_word(W'(10'h2AA), 1'b1, 0, 1'b0, 1'b1);
            check("t6_err_sat", {24'b0, ERR_CNT}, (i + 1 > 255) ? 255 : i + 1);
        end

        idle_cycles(2);
        check("final_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
